// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/ack handshake between the fetch sequencer and imem.
// The fetch address is the separate PC port, because PC also feeds addPC4.
interface pc_fetch_ctrl_if;
    logic imem_req;
    logic imem_ack;

    modport master (output imem_req, input  imem_ack);
    modport slave  (input  imem_req, output imem_ack);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer: follows addPC4 sequentially,
// redirects on branch/jump, and holds one pending redirect while a fetch is outstanding.
module pc_fetch_ctrl #(
    parameter int            AW        = 10,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int            CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] siguiente,
    output logic [AW-1:0] PC,
    input  logic          branch_take,
    input  logic [AW-1:0] branch_target,
    input  logic          jump,
    input  logic [AW-1:0] jump_target,
    input  logic          stall,
    pc_fetch_ctrl_if.master imem,
    output logic          fetch_valid,
    output logic          misalign,
    output logic [CW-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          pend_valid_q, pend_valid_d;
    logic [AW-1:0] pend_tgt_q, pend_tgt_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic          misalign_q, misalign_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          redir_now;
    logic [AW-1:0] redir_raw;
    logic [AW-1:0] redir_aligned;

    // Jump outranks branch; the chosen target is word-aligned before use.
    assign redir_now     = jump | branch_take;
    assign redir_raw     = jump ? jump_target : branch_target;
    assign redir_aligned = {redir_raw[AW-1:2], 2'b00};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_tgt_d    = pend_tgt_q;
        fetch_valid_d = 1'b0;
        misalign_d    = misalign_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            BOOT: begin
                // siguiente is not trusted here: addPC4 may still be in reset.
                state_d = REQ;
            end

            REQ: begin
                if (redir_now && (redir_raw[1:0] != 2'b00)) misalign_d = 1'b1;
                if (imem.imem_ack) begin
                    if (redir_now)         pc_d = redir_aligned;
                    else if (pend_valid_q) pc_d = pend_tgt_q;
                    else                   pc_d = siguiente;
                    // The returned instruction belongs to the old path when any redirect is live.
                    if (!(redir_now || pend_valid_q)) begin
                        fetch_valid_d = 1'b1;
                        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
                    end
                    pend_valid_d = 1'b0;
                    state_d      = stall ? HOLD : REQ;
                end else if (redir_now) begin
                    pend_valid_d = 1'b1;
                    pend_tgt_d   = redir_aligned;
                end
            end

            HOLD: begin
                // Nothing is in flight, so a redirect lands in PC directly with no squash.
                if (redir_now) begin
                    pc_d = redir_aligned;
                    if (redir_raw[1:0] != 2'b00) misalign_d = 1'b1;
                end
                if (!stall) state_d = REQ;
            end

            default: state_d = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; rst is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VEC;
            pend_valid_q  <= 1'b0;
            pend_tgt_q    <= '0;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_tgt_q    <= pend_tgt_d;
            fetch_valid_q <= fetch_valid_d;
            misalign_q    <= misalign_d;
            cnt_q         <= cnt_d;
        end
    end

    assign PC            = pc_q;
    assign imem.imem_req = (state_q == REQ);
    assign fetch_valid   = fetch_valid_q;
    assign misalign      = misalign_q;
    assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with addPC4 modelled as PC + 4; the counter
// width is reduced so that saturation is reachable in a short run.
module tb_pc_fetch_ctrl;

    localparam int AW   = 10;
    localparam int CW_T = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] siguiente;
    logic [AW-1:0] PC;
    logic          branch_take;
    logic [AW-1:0] branch_target;
    logic          jump;
    logic [AW-1:0] jump_target;
    logic          stall;
    logic          fetch_valid;
    logic          misalign;
    logic [CW_T-1:0] fetch_cnt;

    int n_cmp;
    int n_err;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(.AW(AW), .RESET_VEC(10'd0), .CW(CW_T)) dut (
        .clk           (clk),
        .rst           (rst),
        .siguiente     (siguiente),
        .PC            (PC),
        .branch_take   (branch_take),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .stall         (stall),
        .imem          (bus.master),
        .fetch_valid   (fetch_valid),
        .misalign      (misalign),
        .fetch_cnt     (fetch_cnt)
    );

    // addPC4 stand-in; wraps modulo 2^AW by width.
    assign siguiente = PC + 10'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge.
    task automatic cycle(input logic a, input logic s, input logic j, input logic [AW-1:0] jt,
                         input logic b, input logic [AW-1:0] bt);
        bus.imem_ack  = a;
        stall         = s;
        jump          = j;
        jump_target   = jt;
        branch_take   = b;
        branch_target = bt;
        @(posedge clk);
        #1;
    endtask

    task automatic seq(input logic a, input logic s);
        cycle(a, s, 1'b0, 10'd0, 1'b0, 10'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        stall = 1'b0; jump = 1'b0; branch_take = 1'b0;
        jump_target = '0; branch_target = '0;

        // Reset for two cycles.
        seq(1'b0, 1'b0);
        seq(1'b0, 1'b0);
        check("rst_pc",  PC, 0);
        check("rst_req", bus.imem_req, 0);
        check("rst_fv",  fetch_valid, 0);
        check("rst_mis", misalign, 0);
        check("rst_cnt", fetch_cnt, 0);

        // BOOT cycle ignores ack; request appears afterwards.
        rst = 1'b0;
        seq(1'b1, 1'b0);
        check("boot_req", bus.imem_req, 1);
        check("boot_pc",  PC, 0);
        check("boot_fv",  fetch_valid, 0);

        // Sequential run, one ack per cycle.
        for (int k = 1; k <= 4; k++) begin
            seq(1'b1, 1'b0);
            check("seq_pc",  PC, 4 * k);
            check("seq_fv",  fetch_valid, 1);
            check("seq_cnt", fetch_cnt, k);
        end

        // Pending redirect: branch pulsed while ack is low at PC = 16.
        cycle(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 10'd40);
        check("pend_pc0", PC, 16);
        check("pend_fv0", fetch_valid, 0);
        check("pend_req", bus.imem_req, 1);
        seq(1'b0, 1'b0);
        seq(1'b0, 1'b0);
        check("pend_pc2", PC, 16);
        seq(1'b1, 1'b0);
        check("pend_pc",  PC, 40);
        check("pend_fv",  fetch_valid, 0);
        check("pend_cnt", fetch_cnt, 4);
        seq(1'b1, 1'b0);
        check("pend_next_pc", PC, 44);
        check("pend_next_fv", fetch_valid, 1);
        check("pend_next_cnt", fetch_cnt, 5);

        // Jump beats branch at completion.
        cycle(1'b1, 1'b0, 1'b1, 10'd8, 1'b0, 10'd0);
        check("j8_pc", PC, 8);
        cycle(1'b1, 1'b0, 1'b1, 10'd100, 1'b1, 10'd200);
        check("prio_pc",  PC, 100);
        check("prio_fv",  fetch_valid, 0);
        check("prio_cnt", fetch_cnt, 5);
        check("prio_mis", misalign, 0);

        // Stall at completion enters HOLD.
        cycle(1'b1, 1'b0, 1'b1, 10'd20, 1'b0, 10'd0);
        check("j20_pc", PC, 20);
        seq(1'b1, 1'b1);
        check("hold_pc",  PC, 24);
        check("hold_fv",  fetch_valid, 1);
        check("hold_cnt", fetch_cnt, 6);
        check("hold_req", bus.imem_req, 0);
        seq(1'b0, 1'b1);
        check("hold2_pc",  PC, 24);
        check("hold2_req", bus.imem_req, 0);
        check("hold2_fv",  fetch_valid, 0);
        cycle(1'b0, 1'b1, 1'b1, 10'd52, 1'b0, 10'd0);
        check("hold_redir_pc",  PC, 52);
        check("hold_redir_fv",  fetch_valid, 0);
        check("hold_redir_cnt", fetch_cnt, 6);
        check("hold_redir_req", bus.imem_req, 0);
        seq(1'b0, 1'b0);
        check("unhold_req", bus.imem_req, 1);
        check("unhold_pc",  PC, 52);

        // Misaligned jump target is forced to a word boundary, flag is sticky.
        cycle(1'b1, 1'b0, 1'b1, 10'd103, 1'b0, 10'd0);
        check("mis_pc",  PC, 100);
        check("mis_flag", misalign, 1);
        check("mis_fv",  fetch_valid, 0);
        seq(1'b1, 1'b0);
        check("mis_keep_pc",  PC, 104);
        check("mis_keep_flag", misalign, 1);
        check("mis_keep_cnt", fetch_cnt, 7);

        // Wrap 1020 + 4 -> 0.
        cycle(1'b1, 1'b0, 1'b1, 10'd1020, 1'b0, 10'd0);
        check("wrap_pre_pc", PC, 1020);
        seq(1'b1, 1'b0);
        check("wrap_pc",  PC, 0);
        check("wrap_fv",  fetch_valid, 1);
        check("wrap_cnt", fetch_cnt, 8);

        // Counter saturation: 8 + 10 fetches clamps at 15.
        for (int k = 0; k < 10; k++) seq(1'b1, 1'b0);
        check("sat_cnt", fetch_cnt, 15);
        check("sat_pc",  PC, 40);
        check("sat_fv",  fetch_valid, 1);

        // Reset with a request outstanding.
        cycle(1'b1, 1'b0, 1'b1, 10'd48, 1'b0, 10'd0);
        seq(1'b0, 1'b0);
        check("mid_pc",  PC, 48);
        check("mid_req", bus.imem_req, 1);
        rst = 1'b1;
        seq(1'b0, 1'b0);
        check("mid_rst_pc",  PC, 0);
        check("mid_rst_req", bus.imem_req, 0);
        check("mid_rst_cnt", fetch_cnt, 0);
        check("mid_rst_mis", misalign, 0);

        // Reset coinciding with ack produces no fetch_valid.
        rst = 1'b0;
        seq(1'b0, 1'b0);
        seq(1'b1, 1'b0);
        check("re_pc",  PC, 4);
        check("re_fv",  fetch_valid, 1);
        rst = 1'b1;
        seq(1'b1, 1'b0);
        check("rst_ack_fv",  fetch_valid, 0);
        check("rst_ack_pc",  PC, 0);
        check("rst_ack_cnt", fetch_cnt, 0);
        check("rst_ack_req", bus.imem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
